prio_encoder_reg: RTL

Parametrised, registered priority encoder with request latching and a valid/ready output handshake; the clocked, N-input successor to our 4-to-2 combinational encoder. Single-cycle request pulses are captured into a pending register. The highest-priority unmasked pending request is presented as a binary index, and its pending bit is retired when the consumer accepts it. It sits between event sources (interrupt-style pulses) and a single consumer that services one index at a time.

---
 rtl/prio_encoder_reg.sv | 68 ++++++
 1 files changed

// File: rtl/prio_encoder_reg.sv
// prio_encoder_reg: latched request pulses, priority-selected index presented on a valid/ready handshake.
module prio_encoder_reg #(
  parameter int N = 8,
  parameter int MSB_PRIO = 1,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic [W:0]   pend_cnt,
  output logic         overflow
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [N-1:0] pending_q, pending_d, ret, elig;
  logic [W-1:0] out_idx_q, out_idx_d, sel;
  logic [W:0] pend_cnt_q, pend_cnt_d;
  logic overflow_q, overflow_d, acc;
  always_comb begin
    acc = (state_q == HOLD) && out_ready;
    ret = acc ? N'(1) << out_idx_q : '0;
    elig = pending_q & mask & ~ret;
    sel = '0;
    if (MSB_PRIO != 0) begin
      for (int i = 0; i < N; i++) if (elig[i]) sel = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--) if (elig[i]) sel = W'(i);
    end
    pending_d = clear ? '0 : (pending_q & ~ret) | req;
    overflow_d = !clear && (overflow_q || |(req & pending_q & ~ret));
    pend_cnt_d = '0;
    for (int i = 0; i < N; i++) pend_cnt_d = pend_cnt_d + (W+1)'(pending_d[i]);
    // HOLD freezes the index until accepted; IDLE and an accept both reload from elig
    state_d = state_q;
    out_idx_d = out_idx_q;
    if (state_q == IDLE || acc) begin
      state_d = |elig ? HOLD : IDLE;
      out_idx_d = |elig ? sel : out_idx_q;
    end
    if (clear) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      pend_cnt_q <= '0;
      out_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      out_idx_q <= out_idx_d;
      overflow_q <= overflow_d;
    end
  end
  assign out_valid = (state_q == HOLD);
  assign out_idx = out_idx_q;
  assign pending = pending_q;
  assign pend_cnt = pend_cnt_q;
  assign overflow = overflow_q;
endmodule
